// File: rtl/lsu_pkg.sv
// Shared types and constants for the data-memory load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned BE_W = 4;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables, store replication, legality check
// and load extraction/extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic            write,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [31:0]     wdata,
    input  logic [31:0]     rdata,
    output logic [BE_W-1:0] be,
    output logic [31:0]     wdata_rep,
    output logic            ok,
    output logic [31:0]     rdata_ext
);

    logic [31:0] lane;

    always_comb begin
        be        = '0;
        wdata_rep = wdata;
        ok        = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                be        = BE_W'(1) << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                ok        = 1'b1;
            end
            2'b01: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                ok        = ~addr_lo[0];
            end
            2'b10: begin
                be = '1;
                ok = (addr_lo == 2'b00);
            end
            default: ok = 1'b0;
        endcase
        // Only loads have unsigned variants, and only for byte/half.
        if (funct3[2] && (write || funct3[1]))
            ok = 1'b0;
    end

    always_comb begin
        lane = rdata >> {addr_lo, 3'b000};
        case (funct3)
            F3_B:    rdata_ext = {{24{lane[7]}}, lane[7:0]};
            F3_H:    rdata_ext = {{16{lane[15]}}, lane[15:0]};
            F3_BU:   rdata_ext = {24'h000000, lane[7:0]};
            F3_HU:   rdata_ext = {16'h0000, lane[15:0]};
            default: rdata_ext = lane;
        endcase
    end

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store unit between the CPU data port and a variable-latency word memory.
// Optional ACCESS timeout enabled with `define LSU_TIMEOUT_EN.
module data_mem_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_error,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BE_W-1:0]   mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t  state;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic        write_q;
    logic        in_idle;
    logic        al_write;
    logic [2:0]  al_funct3;
    logic [1:0]  al_addr_lo;
    logic [BE_W-1:0] al_be;
    logic [31:0] al_wdata;
    logic        al_ok;
    logic [31:0] al_rdata;
    logic        unused_addr;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt;
`endif

    assign in_idle     = (state == IDLE);
    assign req_ready   = in_idle && !rst;
    assign stall       = !in_idle || (req_valid && req_ready);
    assign unused_addr = ^req_addr[31:ADDR_W+2];

    // One aligner serves both phases: live request while IDLE, latched fields afterwards.
    assign al_write   = in_idle ? req_write       : write_q;
    assign al_funct3  = in_idle ? req_funct3      : funct3_q;
    assign al_addr_lo = in_idle ? req_addr[1:0]   : addr_lo_q;

    lsu_align u_align (
        .write     (al_write),
        .funct3    (al_funct3),
        .addr_lo   (al_addr_lo),
        .wdata     (req_wdata),
        .rdata     (mem_rdata),
        .be        (al_be),
        .wdata_rep (al_wdata),
        .ok        (al_ok),
        .rdata_ext (al_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            funct3_q   <= '0;
            addr_lo_q  <= '0;
            write_q    <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
`ifdef LSU_TIMEOUT_EN
            cnt        <= '0;
`endif
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        funct3_q   <= req_funct3;
                        addr_lo_q  <= req_addr[1:0];
                        write_q    <= req_write;
                        resp_error <= 1'b0;
                        if (al_ok) begin
                            state     <= ACCESS;
                            mem_req   <= 1'b1;
                            mem_we    <= req_write;
                            mem_addr  <= req_addr[ADDR_W+1:2];
                            mem_be    <= al_be;
                            mem_wdata <= al_wdata;
`ifdef LSU_TIMEOUT_EN
                            cnt       <= '0;
`endif
                        end else begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= write_q ? '0 : al_rdata;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_error <= 1'b1;
                        resp_rdata <= '0;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed-vector bench for data_mem_lsu; timeout case needs `define LSU_TIMEOUT_EN.
module tb_data_mem_lsu;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 4;
`else
    localparam int unsigned TB_TIMEOUT = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    data_mem_lsu #(.ADDR_W(10), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request, let it be accepted, return stall seen in the accept cycle.
    task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, output logic acc_stall);
        int unsigned n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        check("req_ready", req_ready, 1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
        #1;
        acc_stall = stall;
        check("stall_accept", stall, 1);
        tick();
        req_valid = 1'b0;
        req_wdata = 32'hDEADBEEF;
        req_addr  = 32'hFFFFFFFF;
    endtask

    // Load with zero-wait memory: checks lanes, result and that the result holds.
    task automatic load_imm(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd,
                            input logic [3:0] exp_be, input logic [31:0] exp_rd);
        logic s;
        mem_ack   = 1'b1;
        mem_rdata = rd;
        issue(1'b0, f3, a, 32'h0, s);
        check("ld_mem_req", mem_req, 1);
        check("ld_mem_we", mem_we, 0);
        check("ld_mem_be", mem_be, exp_be);
        check("ld_valid_early", resp_valid, 0);
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        check("ld_valid", resp_valid, 1);
        check("ld_error", resp_error, 0);
        check("ld_rdata", resp_rdata, exp_rd);
        tick();
        check("ld_valid_drop", resp_valid, 0);
        check("ld_rdata_hold", resp_rdata, exp_rd);
    endtask

    task automatic store_imm(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                             input logic [9:0] exp_addr, input logic [3:0] exp_be,
                             input logic [31:0] exp_wd);
        logic s;
        mem_ack = 1'b1;
        issue(1'b1, f3, a, d, s);
        check("st_mem_req", mem_req, 1);
        check("st_mem_we", mem_we, 1);
        check("st_mem_addr", mem_addr, exp_addr);
        check("st_mem_be", mem_be, exp_be);
        check("st_mem_wdata", mem_wdata, exp_wd);
        check("st_valid_early", resp_valid, 0);
        tick();
        mem_ack = 1'b0;
        check("st_valid", resp_valid, 1);
        check("st_error", resp_error, 0);
        check("st_rdata", resp_rdata, 0);
        check("st_mem_req_drop", mem_req, 0);
        tick();
        check("st_valid_drop", resp_valid, 0);
    endtask

    task automatic bad_req(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        logic s;
        check("bad_pre_mem_req", mem_req, 0);
        issue(wr, f3, a, 32'h12345678, s);
        check("bad_valid", resp_valid, 1);
        check("bad_error", resp_error, 1);
        check("bad_rdata", resp_rdata, 0);
        check("bad_mem_req", mem_req, 0);
        tick();
        check("bad_valid_drop", resp_valid, 0);
        check("bad_error_hold", resp_error, 1);
        check("bad_mem_req2", mem_req, 0);
        check("bad_ready", req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic s;
        int   st;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'h0;

        tick();
        tick();
        check("rst_ready", req_ready, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_valid", resp_valid, 0);
        check("rst_stall", stall, 0);
        check("rst_rdata", resp_rdata, 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", req_ready, 1);
        tick();

        // Stores: lane placement, replication and address wrap.
        store_imm(3'b000, 32'h00000006, 32'h0BADF00D, 10'd1,     4'b0100, 32'h0D0D0D0D);
        store_imm(3'b001, 32'h00000002, 32'h12345678, 10'd0,     4'b1100, 32'h56785678);
        store_imm(3'b001, 32'h00000010, 32'hCAFEBABE, 10'd4,     4'b0011, 32'hBABEBABE);
        store_imm(3'b010, 32'h0000000C, 32'hA5A55A5A, 10'd3,     4'b1111, 32'hA5A55A5A);
        store_imm(3'b000, 32'h00001005, 32'h000000EE, 10'h001,   4'b0010, 32'hEEEEEEEE);

        // Loads: extraction and extension.
        load_imm(3'b000, 32'h3, 32'h80ADF01D, 4'b1000, 32'hFFFFFF80);
        load_imm(3'b100, 32'h3, 32'h80ADF01D, 4'b1000, 32'h00000080);
        load_imm(3'b101, 32'h2, 32'h80ADF01D, 4'b1100, 32'h000080AD);
        load_imm(3'b001, 32'h2, 32'h80ADF01D, 4'b1100, 32'hFFFF80AD);
        load_imm(3'b000, 32'h1, 32'h80ADF01D, 4'b0010, 32'hFFFFFFF0);
        load_imm(3'b000, 32'h0, 32'h80ADF01D, 4'b0001, 32'h0000001D);
        load_imm(3'b001, 32'h0, 32'h1234F01D, 4'b0011, 32'hFFFFF01D);
        load_imm(3'b010, 32'h4, 32'h80ADF01D, 4'b1111, 32'h80ADF01D);

        // Misaligned and illegal requests.
        bad_req(1'b0, 3'b001, 32'h1);
        bad_req(1'b1, 3'b010, 32'h2);
        bad_req(1'b0, 3'b011, 32'h0);
        bad_req(1'b0, 3'b110, 32'h0);
        bad_req(1'b1, 3'b100, 32'h0);

        // LW with five ACCESS cycles; mem outputs must hold steady.
        mem_ack = 1'b0;
        issue(1'b0, 3'b010, 32'h8, 32'h0, s);
        st = int'(s);
        check("lw_error_cleared", resp_error, 0);
        for (int i = 1; i <= 5; i++) begin
            if (i > 1) tick();
            st += int'(stall);
            check("lw_mem_req", mem_req, 1);
            check("lw_mem_we", mem_we, 0);
            check("lw_mem_addr", mem_addr, 2);
            check("lw_mem_be", mem_be, 4'b1111);
            check("lw_no_valid", resp_valid, 0);
            if (i == 5) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'h0BADF01D;
            end
        end
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        st += int'(stall);
        check("lw_valid", resp_valid, 1);
        check("lw_rdata", resp_rdata, 32'h0BADF01D);
        check("lw_error", resp_error, 0);
        tick();
        check("lw_stall_idle", stall, 0);
        check("lw_stall_cycles", st, 7);
        check("lw_valid_drop", resp_valid, 0);

        // Reset during an ACCESS wait, then a late ack.
        issue(1'b0, 3'b010, 32'h10, 32'h0, s);
        check("rstm_mem_req", mem_req, 1);
        tick();
        rst = 1'b1;
        tick();
        check("rstm_mem_req_drop", mem_req, 0);
        check("rstm_no_valid", resp_valid, 0);
        check("rstm_ready_in_rst", req_ready, 0);
        rst     = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'h11111111;
        #1;
        check("rstm_ready", req_ready, 1);
        tick();
        mem_ack = 1'b0;
        check("rstm_late_ack_valid", resp_valid, 0);
        check("rstm_late_ack_req", mem_req, 0);
        check("rstm_rdata", resp_rdata, 0);

`ifdef LSU_TIMEOUT_EN
        issue(1'b0, 3'b010, 32'h0, 32'h0, s);
        for (int i = 0; i < 4; i++) begin
            check("to_mem_req", mem_req, 1);
            check("to_no_valid", resp_valid, 0);
            tick();
        end
        check("to_valid", resp_valid, 1);
        check("to_error", resp_error, 1);
        check("to_rdata", resp_rdata, 0);
        check("to_mem_req_drop", mem_req, 0);
        tick();
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'h22222222;
        tick();
        mem_ack = 1'b0;
        check("to_late_ack_valid", resp_valid, 0);
        check("to_late_ack_req", mem_req, 0);
        check("to_late_ack_ready", req_ready, 1);
`else
        issue(1'b0, 3'b010, 32'h0, 32'h0, s);
        for (int i = 0; i < 10; i++) begin
            check("wait_mem_req", mem_req, 1);
            check("wait_no_valid", resp_valid, 0);
            tick();
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h33333333;
        tick();
        mem_ack = 1'b0;
        check("wait_valid", resp_valid, 1);
        check("wait_error", resp_error, 0);
        check("wait_rdata", resp_rdata, 32'h33333333);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
